// File: rtl/axis_frame_gen_pkg.sv
// rtl/axis_frame_gen_pkg.sv - shared types and constants for the AXI-Stream frame generator.
package axis_frame_gen_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic {
    PAT_CNT,
    PAT_LFSR
  } pat_t;

  // Galois feedback taps for the 32-bit pattern LFSR
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

endpackage

// File: rtl/axis_frame_gen_next.sv
// rtl/axis_frame_gen_next.sv - combinational next pattern word (counter, or LFSR with AXIS_FRAME_GEN_LFSR_EN).
module axis_frame_gen_next
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] cur,
`ifdef AXIS_FRAME_GEN_LFSR_EN
  input  pat_t                  mode,
`endif
  output logic [DATA_WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur + DATA_WIDTH'(1);
`ifdef AXIS_FRAME_GEN_LFSR_EN
    if (mode == PAT_LFSR) begin
      nxt = (cur >> 1) ^ (cur[0] ? DATA_WIDTH'(LFSR_MASK) : '0);
    end
`endif
  end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI-Stream master emitting one counter/LFSR frame per start pulse.
// Optional LFSR pattern (and pattern_sel port) built when AXIS_FRAME_GEN_LFSR_EN is defined.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [DATA_WIDTH-1:0] seed,
`ifdef AXIS_FRAME_GEN_LFSR_EN
  input  logic                  pattern_sel,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_cnt,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast
);

`ifdef AXIS_FRAME_GEN_LFSR_EN
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("axis_frame_gen: LFSR pattern requires DATA_WIDTH == 32");
  end
`endif

  state_t                state, state_n;
  logic [LEN_WIDTH-1:0]  len_q, len_n;
  logic [LEN_WIDTH-1:0]  beat, beat_n;
  logic [DATA_WIDTH-1:0] tdata_n, word_next, first_word;
  logic                  tvalid_n, tlast_n, busy_n, done_n;
  logic [15:0]           cnt_n;
  logic [LEN_WIDTH-1:0]  beat_inc, len_m1;

`ifdef AXIS_FRAME_GEN_LFSR_EN
  pat_t mode, mode_n;

  // An all-zero LFSR state would lock up, so a zero seed starts at 1
  assign first_word = (pattern_sel && seed == '0) ? DATA_WIDTH'(1) : seed;

  axis_frame_gen_next #(.DATA_WIDTH(DATA_WIDTH)) u_next (
    .cur  (m_axis_tdata),
    .mode (mode),
    .nxt  (word_next)
  );
`else
  assign first_word = seed;

  axis_frame_gen_next #(.DATA_WIDTH(DATA_WIDTH)) u_next (
    .cur (m_axis_tdata),
    .nxt (word_next)
  );
`endif

  assign beat_inc = beat + LEN_WIDTH'(1);
  assign len_m1   = len_q - LEN_WIDTH'(1);

  always_comb begin
    state_n  = state;
    len_n    = len_q;
    beat_n   = beat;
    tdata_n  = m_axis_tdata;
    tvalid_n = m_axis_tvalid;
    tlast_n  = m_axis_tlast;
    busy_n   = busy;
    done_n   = 1'b0;
    cnt_n    = frame_cnt;
`ifdef AXIS_FRAME_GEN_LFSR_EN
    mode_n   = mode;
`endif
    case (state)
      IDLE: begin
        if (start && frame_len != '0) begin
          state_n  = RUN;
          len_n    = frame_len;
          beat_n   = '0;
          tdata_n  = first_word;
          tvalid_n = 1'b1;
          tlast_n  = (frame_len == LEN_WIDTH'(1));
          busy_n   = 1'b1;
`ifdef AXIS_FRAME_GEN_LFSR_EN
          mode_n   = pattern_sel ? PAT_LFSR : PAT_CNT;
`endif
        end
      end
      RUN: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            state_n  = IDLE;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            cnt_n    = frame_cnt + 16'd1;
          end else begin
            beat_n   = beat_inc;
            tdata_n  = word_next;
            tlast_n  = (beat_inc == len_m1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      len_q         <= '0;
      beat          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_cnt     <= '0;
`ifdef AXIS_FRAME_GEN_LFSR_EN
      mode          <= PAT_CNT;
`endif
    end else begin
      state         <= state_n;
      len_q         <= len_n;
      beat          <= beat_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      busy          <= busy_n;
      done          <= done_n;
      frame_cnt     <= cnt_n;
`ifdef AXIS_FRAME_GEN_LFSR_EN
      mode          <= mode_n;
`endif
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - randomized self-checking bench for axis_frame_gen against a frame-level word-list model.
module tb_axis_frame_gen;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] seed;
`ifdef AXIS_FRAME_GEN_LFSR_EN
  logic          pattern_sel;
`endif
  logic          busy, done;
  logic [15:0]   frame_cnt;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;

  always #5 aclk = ~aclk;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .frame_len     (frame_len),
    .seed          (seed),
`ifdef AXIS_FRAME_GEN_LFSR_EN
    .pattern_sel   (pattern_sel),
`endif
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast)
  );

  int            checks = 0;
  int            failures = 0;
  logic [15:0]   exp_cnt = 16'd0;
  logic [DW-1:0] exp_q[$];
  int            bp_pat[6] = '{1, 0, 0, 1, 0, 1};
  int            bp_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Expected frame contents straight from the pattern rules
  task automatic build(input int len, input logic [DW-1:0] sd, input bit pat);
    logic [DW-1:0] w;
    exp_q.delete();
    w = (pat && sd == '0) ? DW'(1) : sd;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(w);
      w = pat ? lfsr_step(w) : w + DW'(1);
    end
  endtask

  // bp: 0 always ready, -1 fixed toggle pattern, else percent chance of ready
  task automatic pick_ready(input int bp);
    if (bp == 0) tready = 1'b1;
    else if (bp < 0) begin
      tready = bp_pat[bp_idx % 6] != 0;
      bp_idx++;
    end else tready = ($urandom_range(0, 99) < bp);
  endtask

  task automatic do_start(input int len, input logic [DW-1:0] sd, input bit pat, input int bp);
    frame_len = LW'(len);
    seed      = sd;
`ifdef AXIS_FRAME_GEN_LFSR_EN
    pattern_sel = pat;
`endif
    start     = 1'b1;
    bp_idx    = 0;
    @(posedge aclk);
    #1;
    start = 1'b0;
    pick_ready(bp);
  endtask

  task automatic consume(input int len, input logic [DW-1:0] sd, input bit pat, input int bp,
                         input bit mid_start);
    int idx;
    int cyc;
    bit hs;
    build(len, sd, pat);
    if (len == 0) begin
      repeat (3) begin
        @(negedge aclk);
        check("len0_tvalid", tvalid, 0);
        check("len0_done", done, 0);
      end
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 500) begin
      @(negedge aclk);
      check("tvalid_hold", tvalid, 1);
      check("busy_run", busy, 1);
      check("tdata", tdata, exp_q[idx]);
      check("tlast", tlast, (idx == len - 1));
      check("done_mid", done, 0);
      hs = tready;
      if (mid_start && cyc == 1) begin
        start     = 1'b1;
        frame_len = LW'(5);
        seed      = $urandom;
      end
      @(posedge aclk);
      #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
      pick_ready(bp);
    end
    if (idx < len) check("frame_timeout", idx, len);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge aclk);
    check("done_pulse", done, 1);
    check("tvalid_gap", tvalid, 0);
    check("tlast_clear", tlast, 0);
    check("busy_clear", busy, 0);
    check("frame_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    int len;
    logic [DW-1:0] sd;
    bit pat;
    int bp;

    areset = 1'b1;
    start = 1'b0;
    frame_len = '0;
    seed = '0;
`ifdef AXIS_FRAME_GEN_LFSR_EN
    pattern_sel = 1'b0;
`endif
    tready = 1'b0;
    #12;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    do_start(4, 32'h10, 0, 0);
    consume(4, 32'h10, 0, 0, 0);
    do_start(3, 32'h100, 0, -1);
    consume(3, 32'h100, 0, -1, 0);
    do_start(0, 32'h5, 0, 0);
    consume(0, 32'h5, 0, 0, 0);
    do_start(1, 32'h55, 0, 0);
    consume(1, 32'h55, 0, 0, 0);
    do_start(2, 32'hFFFF_FFFF, 0, 0);
    consume(2, 32'hFFFF_FFFF, 0, 0, 0);
`ifdef AXIS_FRAME_GEN_LFSR_EN
    do_start(3, 32'h1, 1, 0);
    consume(3, 32'h1, 1, 0, 0);
    do_start(3, 32'h0, 1, 60);
    consume(3, 32'h0, 1, 60, 0);
`endif

    // start in the done cycle: next frame follows after a one-cycle gap
    do_start(3, 32'hA0, 0, 0);
    consume(3, 32'hA0, 0, 0, 0);
    do_start(2, 32'hB0, 0, 0);
    consume(2, 32'hB0, 0, 0, 0);

    // start pulsed mid-frame is neither honoured nor queued
    do_start(4, 32'hC0, 0, 0);
    consume(4, 32'hC0, 0, 0, 1);
    @(negedge aclk);
    check("no_queue_tvalid", tvalid, 0);
    check("no_queue_busy", busy, 0);

    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(0, 10);
      case ($urandom_range(0, 3))
        0: sd = 32'hFFFF_FFFF - DW'($urandom_range(0, 4));
        1: sd = '0;
        default: sd = $urandom;
      endcase
`ifdef AXIS_FRAME_GEN_LFSR_EN
      pat = $urandom_range(0, 1) != 0;
`else
      pat = 1'b0;
`endif
      bp = $urandom_range(30, 100);
      if (bp == 100) bp = 0;
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      do_start(len, sd, pat, bp);
      consume(len, sd, pat, bp, $urandom_range(0, 3) == 0);
    end

    // asynchronous reset mid-frame
    do_start(10, 32'h0, 0, 0);
    @(negedge aclk);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tlast", tlast, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_cnt = 16'd0;
    repeat (3) begin
      @(negedge aclk);
      check("post_rst_tvalid", tvalid, 0);
      check("post_rst_done", done, 0);
    end
    do_start(2, 32'h7, 0, 0);
    consume(2, 32'h7, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

AXI4-Stream master that generates one frame of `frame_len` data words ending in `tlast`. The words are an incrementing counter, or optionally an LFSR sequence. It is the source end for the DMA S2MM path: it feeds stream data into memory the same way the multiplier consumes and returns MM2S data, and it allows DMA receive-path testing without a software-supplied payload. Control is a one-cycle `start` pulse, with `busy`/`done` status and a running frame count.

## Interface
- `DATA_WIDTH`, 32, width of the stream data bus and the pattern word.
- `LEN_WIDTH`, 16, width of `frame_len`; the maximum frame is 2^LEN_WIDTH−1 words.
- `aclk` input 1: the single clock; all logic is on the rising edge.
- `areset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to emit a frame; sampled only in IDLE.
- `frame_len` input LEN_WIDTH: number of words in the frame; latched on an accepted `start`.
- `seed` input DATA_WIDTH: first data word; latched on an accepted `start`.
- `pattern_sel` input 1: 0 = counter, 1 = LFSR. Present only when `AXIS_FRAME_GEN_LFSR_EN` is defined.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse after the final handshake.
- `frame_cnt` output 16: number of frames completed; wraps at 2^16.
- `m_axis_tready` input 1: downstream ready.
- `m_axis_tdata` output DATA_WIDTH: current word.
- `m_axis_tvalid` output 1: word valid.
- `m_axis_tlast` output 1: high on the last word of the frame.

## Operation
- FSM states are IDLE and RUN. All outputs are registered.
- **IDLE → RUN:** requires `start`=1 and `frame_len`≠0.
  - On the transition, latch `frame_len`, latch the pattern mode, set `tdata`=`seed`, clear `beat`, and assert `tvalid`.
  - `start` with `frame_len`=0 is ignored: no output and no `done`.
- **Handshake:** a beat transfers when `tvalid`&&`tready`. On each handshake:
  - `beat` increments.
  - `tdata` advances to the next pattern word.
  - `tlast` = (`beat` == `len`−1) for the word being presented.
- **RUN → IDLE:** on the handshake with `tlast`=1.
  - Same edge: `tvalid`←0, `tlast`←0, `busy`←0, `done`←1 for one cycle, `frame_cnt`←`frame_cnt`+1 (mod 2^16).
- `start` during RUN is ignored. It is not queued.
- **Counter pattern:** next = `tdata`+1 mod 2^DATA_WIDTH. It wraps from all-ones to 0.
- **LFSR pattern** (Galois): next = (s>>1) ^ (s[0] ? 32'h80200003 : 0). A `seed` of 0 is replaced by 1 at latch time.
- `beat` width is LEN_WIDTH. Comparisons are unsigned.

## Timing
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `frame_cnt`=0. State is IDLE.
- **Latency:** `start` sampled at edge N gives `tvalid`, `busy`, and the first word visible after edge N. Throughput is 1 word/cycle while `tready`=1.
- **Stream stability:** once asserted, `tvalid` stays high until the last handshake. `tdata` and `tlast` are held stable while `tvalid`&&!`tready`.
- **1-word frame:** `tlast`=1 together with the first `tvalid`.
- **Back-to-back frames:** `start` may be asserted in the `done` cycle. The next frame's first word follows on the next edge, so the minimum gap is one cycle with `tvalid` low.
- **Reset mid-frame:** outputs clear immediately (asynchronously). No `tlast` and no `done` are produced; `frame_cnt` returns to 0.

## Configuration
- `AXIS_FRAME_GEN_LFSR_EN` defined:
  - `pattern_sel` port exists.
  - The LFSR next-word path is built.
  - DATA_WIDTH must equal 32; elaboration fails otherwise.
- `AXIS_FRAME_GEN_LFSR_EN` undefined:
  - No `pattern_sel` port.
  - Counter pattern only.
  - DATA_WIDTH is unrestricted.

## Structure
- Package `axis_frame_gen_pkg` holds:
  - the state enum (IDLE, RUN);
  - the `LFSR_MASK` constant 32'h80200003;
  - the pattern-mode enum (PAT_CNT, PAT_LFSR).
- Sub-module `axis_frame_gen_next`: combinational next-word function taking current word and mode. It isolates the counter/LFSR selection from the FSM.

## Test plan
- **Counter frame, free-flowing:** `frame_len`=4, `seed`=0x10, `tready`=1 → words 0x10, 0x11, 0x12, 0x13 on consecutive cycles; `tlast` only on 0x13; `done` one cycle later; `frame_cnt`=1.
- **Backpressure:** `frame_len`=3, `tready` toggling 1,0,0,1,0,1 → `tdata`/`tlast` held while stalled; exactly 3 handshakes; `tvalid` never drops mid-frame.
- **Edge lengths:** `frame_len`=0 → no `tvalid`, no `done`. `frame_len`=1 → a single word with `tlast`=1. Counter `seed`=0xFFFFFFFF, `frame_len`=2 → 0xFFFFFFFF, 0x00000000.
- **LFSR (macro defined):** `pattern_sel`=1, `seed`=1, `frame_len`=3 → 0x00000001, 0x80200003, 0xC0300002. `seed`=0 gives the same sequence.
- **Back-to-back, ignored start, reset:**
  - `start` in the `done` cycle → second frame starts with a one-cycle gap.
  - `start` pulsed mid-frame → ignored.
  - `areset` mid-frame → `tvalid`=0 immediately and `frame_cnt`=0.
